// File: rtl/cmd_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// cmd_fetch_ctrl
//   Instruction-fetch sequencer for the CPU command memory. It holds the
//   program counter, issues a one-cycle read strobe plus address to the
//   registered command memory, waits for the acknowledge, captures the
//   command word and presents it to the decoder over a valid/ready
//   handshake. It supports start/resume, halting at an instruction
//   boundary, jumping on handoff, PC wrap and an acknowledge timeout.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        begin/resume fetching (level, honoured in IDLE/HALT)
//   halt_req_i     request a stop at the next instruction boundary
//   jmp_en_i       take jmp_adr_i as next PC on the current handoff
//   jmp_adr_i      jump target PC
//   mem_req_o      one-cycle read strobe to the command memory
//   mem_adr_o      read address
//   mem_cmd_i      command word returned by the memory
//   mem_ack_i      memory data valid (one cycle after the strobe)
//   instr_o        captured command word to the decoder
//   instr_valid_o  instr_o valid
//   instr_ready_i  decoder accepts instr_o
//   pc_o           address of the instruction in flight / next to fetch
//   busy_o         high while fetching or holding an instruction
//   err_timeout_o  sticky: memory failed to acknowledge in time
// ---------------------------------------------------------------------------
module cmd_fetch_ctrl #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned CMD_W    = 16,
    parameter int unsigned PROG_LEN = 4,
    parameter int unsigned TIMEOUT  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              halt_req_i,
    input  logic              jmp_en_i,
    input  logic [ADDR_W-1:0] jmp_adr_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_adr_o,
    input  logic [CMD_W-1:0]  mem_cmd_i,
    input  logic              mem_ack_i,
    output logic [CMD_W-1:0]  instr_o,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              busy_o,
    output logic              err_timeout_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    // One extra bit so a target equal to 2**ADDR_W-1 compares correctly
    localparam logic [ADDR_W:0]   PROG_LEN_X = (ADDR_W + 1)'(PROG_LEN);
    localparam logic [ADDR_W-1:0] PC_LAST    = ADDR_W'(PROG_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_HALT  = 3'd4
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                halt_q;
    logic                mem_req_q;
    logic [ADDR_W-1:0]   mem_adr_q;
    logic [CMD_W-1:0]    instr_q;
    logic                instr_valid_q;
    logic                busy_q;
    logic                err_q;

    // PC to load on a handoff: jump target (out-of-range -> 0) or wrapped increment
    always_comb begin
        pc_d = '0;
        if (jmp_en_i) begin
            if ({1'b0, jmp_adr_i} < PROG_LEN_X) begin
                pc_d = jmp_adr_i;
            end
        end else if (pc_q != PC_LAST) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    // Wait-cycle counter increment
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
    end

    // Fetch sequencer; every output is a register updated alongside the state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            cnt_q         <= '0;
            halt_q        <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_adr_q     <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            // Strobe is a single-cycle pulse unless re-armed below
            mem_req_q <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q   <= S_ISSUE;
                        mem_req_q <= 1'b1;
                        mem_adr_q <= pc_q;
                        busy_q    <= 1'b1;
                    end
                end

                S_ISSUE: begin
                    state_q <= S_WAIT;
                    cnt_q   <= '0;
                    if (halt_req_i) begin
                        halt_q <= 1'b1;
                    end
                end

                S_WAIT: begin
                    if (halt_req_i) begin
                        halt_q <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        state_q       <= S_HOLD;
                        instr_q       <= mem_cmd_i;
                        instr_valid_q <= 1'b1;
                    end else if (cnt_d == CNT_LIMIT) begin
                        // Memory never answered: park in HALT until reset
                        state_q <= S_HALT;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        halt_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_HOLD: begin
                    if (instr_ready_i) begin
                        instr_valid_q <= 1'b0;
                        pc_q          <= pc_d;
                        // A request on the transfer edge itself still counts
                        if (halt_q || halt_req_i) begin
                            state_q <= S_HALT;
                            busy_q  <= 1'b0;
                            halt_q  <= 1'b0;
                        end else begin
                            state_q   <= S_ISSUE;
                            mem_req_q <= 1'b1;
                            mem_adr_q <= pc_d;
                        end
                    end else if (halt_req_i) begin
                        halt_q <= 1'b1;
                    end
                end

                S_HALT: begin
                    if (start_i && !err_q) begin
                        state_q   <= S_ISSUE;
                        mem_req_q <= 1'b1;
                        mem_adr_q <= pc_q;
                        busy_q    <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_o     = mem_req_q;
    assign mem_adr_o     = mem_adr_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = instr_valid_q;
    assign pc_o          = pc_q;
    assign busy_o        = busy_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_cmd_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cmd_fetch_ctrl
//   Directed and randomized checks of cmd_fetch_ctrl against a registered
//   command-memory model and a transaction-level PC/instruction model.
// ---------------------------------------------------------------------------
module tb_cmd_fetch_ctrl;

    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned CMD_W    = 16;
    localparam int unsigned PROG_LEN = 4;
    localparam int unsigned TIMEOUT  = 8;

    logic              clk           = 1'b0;
    logic              rst           = 1'b1;
    logic              start         = 1'b0;
    logic              halt_req      = 1'b0;
    logic              jmp_en        = 1'b0;
    logic [ADDR_W-1:0] jmp_adr       = '0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_adr;
    logic [CMD_W-1:0]  mem_cmd       = '0;
    logic              mem_ack       = 1'b0;
    logic [CMD_W-1:0]  instr;
    logic              instr_valid;
    logic              instr_ready   = 1'b0;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              err_timeout;

    logic              ack_en        = 1'b1;
    logic              spur          = 1'b0;
    logic [CMD_W-1:0]  rom [16];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    cmd_fetch_ctrl #(
        .ADDR_W   (ADDR_W),
        .CMD_W    (CMD_W),
        .PROG_LEN (PROG_LEN),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .halt_req_i    (halt_req),
        .jmp_en_i      (jmp_en),
        .jmp_adr_i     (jmp_adr),
        .mem_req_o     (mem_req),
        .mem_adr_o     (mem_adr),
        .mem_cmd_i     (mem_cmd),
        .mem_ack_i     (mem_ack),
        .instr_o       (instr),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .pc_o          (pc),
        .busy_o        (busy),
        .err_timeout_o (err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered command memory: ack and data one cycle after the strobe;
    // spur injects an unsolicited ack carrying a poison word.
    always @(posedge clk) begin
        mem_ack <= (mem_req & ack_en) | spur;
        mem_cmd <= spur ? 16'hDEAD : rom[mem_adr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until a read strobe is seen, bounded by a cycle budget
    task automatic wait_req(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (mem_req === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk(tag, 32'(found), 32'd1);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        start       = 1'b0;
        halt_req    = 1'b0;
        jmp_en      = 1'b0;
        jmp_adr     = '0;
        instr_ready = 1'b0;
        spur        = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   32'(mem_req),     32'd0);
        chk({tag, "_adr"},   32'(mem_adr),     32'd0);
        chk({tag, "_instr"}, 32'(instr),       32'd0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_pc"},    32'(pc),          32'd0);
        chk({tag, "_busy"},  32'(busy),        32'd0);
        chk({tag, "_err"},   32'(err_timeout), 32'd0);
    endtask

    // Reference PC rule: jump target (out of program -> 0) or wrapping increment
    function automatic int unsigned model_next(input int unsigned cur, input bit je,
                                               input int unsigned ja);
        if (je) return (ja < PROG_LEN) ? ja : 0;
        return (cur + 1) % PROG_LEN;
    endfunction

    initial begin
        int prev_cyc;
        int unsigned exp_pc;
        int unsigned n_xfer;
        bit          r_ready;
        bit          r_jmp;
        int unsigned r_adr;

        for (int i = 0; i < 16; i++) rom[i] = '0;
        rom[0] = 16'h0C03;
        rom[1] = 16'h0E46;
        rom[2] = 16'h1003;
        rom[3] = 16'h1203;

        // ---- reset state ----
        do_reset();
        chk_all_zero("reset");

        // ---- streaming with ready high, PC wraps 3 -> 0 ----
        instr_ready = 1'b1;
        start       = 1'b1;
        exp_pc      = 0;
        prev_cyc    = 0;
        for (int k = 0; k < 5; k++) begin
            wait_req("stream_req_timeout");
            start = 1'b0;
            chk("stream_adr", 32'(mem_adr), 32'(exp_pc));
            chk("stream_pc",  32'(pc),      32'(exp_pc));
            chk("stream_busy", 32'(busy),   32'd1);
            if (k > 0) chk("stream_period", 32'(cyc - prev_cyc), 32'd3);
            prev_cyc = cyc;
            step();
            chk("stream_req_pulse", 32'(mem_req), 32'd0);
            step();
            chk("stream_valid", 32'(instr_valid), 32'd1);
            chk("stream_instr", 32'(instr), 32'(rom[4'(exp_pc)]));
            exp_pc = (exp_pc + 1) % PROG_LEN;
        end

        // ---- backpressure: instr held, no new fetch, spurious ack ignored ----
        do_reset();
        start = 1'b1;
        wait_req("bp_req_timeout");
        start = 1'b0;
        step();
        step();
        chk("bp_first_valid", 32'(instr_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            spur = (i == 2);
            step();
            chk("bp_valid", 32'(instr_valid), 32'd1);
            chk("bp_instr", 32'(instr), 32'h0C03);
            chk("bp_no_req", 32'(mem_req), 32'd0);
        end
        spur        = 1'b0;
        instr_ready = 1'b1;
        step();
        chk("bp_resume_req", 32'(mem_req), 32'd1);
        chk("bp_resume_adr", 32'(mem_adr), 32'd1);

        // ---- jump on handoff, in-range and out-of-range target ----
        do_reset();
        instr_ready = 1'b1;
        jmp_en      = 1'b1;
        jmp_adr     = 4'd3;
        start       = 1'b1;
        wait_req("jmp_req0_timeout");
        start = 1'b0;
        chk("jmp_adr0", 32'(mem_adr), 32'd0);
        wait_req("jmp_req1_timeout");
        chk("jmp_adr3", 32'(mem_adr), 32'd3);
        jmp_adr = 4'd9;
        step();
        step();
        chk("jmp_instr3", 32'(instr), 32'h1203);
        wait_req("jmp_req2_timeout");
        chk("jmp_oor_adr", 32'(mem_adr), 32'd0);
        chk("jmp_oor_pc",  32'(pc),      32'd0);
        jmp_en = 1'b0;
        wait_req("jmp_req3_timeout");
        chk("jmp_seq_adr", 32'(mem_adr), 32'd1);

        // ---- halt during WAIT completes the fetch, then resume ----
        do_reset();
        instr_ready = 1'b1;
        start       = 1'b1;
        wait_req("halt_req0_timeout");
        start = 1'b0;
        wait_req("halt_req1_timeout");
        chk("halt_adr1", 32'(mem_adr), 32'd1);
        step();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        chk("halt_valid", 32'(instr_valid), 32'd1);
        chk("halt_instr", 32'(instr), 32'h0E46);
        step();
        chk("halt_busy",  32'(busy),        32'd0);
        chk("halt_pc",    32'(pc),          32'd2);
        chk("halt_valid_clr", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_idle_req", 32'(mem_req), 32'd0);
        end
        start = 1'b1;
        wait_req("resume_req_timeout");
        start = 1'b0;
        chk("resume_adr", 32'(mem_adr), 32'd2);
        step();
        step();
        chk("resume_instr", 32'(instr), 32'h1003);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        chk("halt_edge_busy", 32'(busy), 32'd0);
        chk("halt_edge_pc",   32'(pc),   32'd3);
        step();
        chk("halt_edge_no_req", 32'(mem_req), 32'd0);

        // ---- acknowledge timeout ----
        do_reset();
        ack_en = 1'b0;
        start  = 1'b1;
        wait_req("to_req_timeout");
        start = 1'b0;
        for (int i = 1; i <= int'(TIMEOUT) + 1; i++) begin
            step();
            chk("to_err",  32'(err_timeout), 32'(i == int'(TIMEOUT) + 1));
            chk("to_busy", 32'(busy),        32'(i != int'(TIMEOUT) + 1));
        end
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to_start_ignored", 32'(mem_req), 32'd0);
            chk("to_err_sticky", 32'(err_timeout), 32'd1);
        end
        ack_en = 1'b1;
        do_reset();
        chk_all_zero("to_reset");

        // ---- reset during WAIT with ack present, then spurious ack in IDLE ----
        start = 1'b1;
        wait_req("rw_req_timeout");
        start = 1'b0;
        step();
        rst  = 1'b1;
        spur = 1'b1;
        step();
        rst  = 1'b0;
        spur = 1'b0;
        chk("rw_instr", 32'(instr),       32'd0);
        chk("rw_valid", 32'(instr_valid), 32'd0);
        chk("rw_pc",    32'(pc),          32'd0);
        chk("rw_busy",  32'(busy),        32'd0);
        step();
        chk("rw_spur_instr", 32'(instr),       32'd0);
        chk("rw_spur_valid", 32'(instr_valid), 32'd0);

        // ---- randomized ready/jump against the reference model ----
        do_reset();
        instr_ready = 1'b1;
        start       = 1'b1;
        step();
        start  = 1'b0;
        exp_pc = 0;
        n_xfer = 0;
        for (int c = 0; c < 300; c++) begin
            chk("rnd_pc", 32'(pc), 32'(exp_pc));
            if (mem_req) chk("rnd_adr", 32'(mem_adr), 32'(exp_pc));
            if (instr_valid) chk("rnd_instr", 32'(instr), 32'(rom[4'(exp_pc)]));
            r_ready     = ($urandom_range(0, 1) == 1);
            r_jmp       = ($urandom_range(0, 3) == 0);
            r_adr       = $urandom_range(0, 15);
            instr_ready = r_ready;
            jmp_en      = r_jmp;
            jmp_adr     = 4'(r_adr);
            if (instr_valid && r_ready) begin
                exp_pc = model_next(exp_pc, r_jmp, r_adr);
                n_xfer++;
            end
            step();
        end
        chk("rnd_xfers_seen", 32'(n_xfer > 20), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
